// File: rtl/guitar_pkg.sv
// Shared types and constants for the note playback path: play states, system modes,
// and the per-row lookup used to build the scrolling lane windows.
package guitar_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COUNTDOWN = 2'd1,
      PLAY      = 2'd2,
      DONE      = 2'd3
   } play_state_t;

   localparam logic [2:0] MODE_EDIT = 3'd2;
   localparam logic [2:0] MODE_PLAY = 3'd3;
   localparam int         SONG_LEN  = 32;

   // Row k of a lane shows the note k steps after the current one; past bit 0 the row is empty.
   function automatic logic lane_row(input logic [31:0] pat, input logic [4:0] idx, input int k);
      logic [5:0] d;
      d = {1'b0, idx} - 6'(k);
      return d[5] ? 1'b0 : pat[d[4:0]];
   endfunction

endpackage

// File: rtl/note_scroller_step_timer.sv
// Song tempo generator: counts clk cycles while enabled and emits a one-cycle
// step_pulse on the last cycle of every TICKS_PER_STEP-cycle step.
module step_timer #(
   parameter int TICKS_PER_STEP = 1_000_000
) (
   input  logic clk,
   input  logic nrst,
   input  logic clr,
   input  logic en,
   output logic step_pulse
);

   localparam int            TW = $clog2(TICKS_PER_STEP);
   localparam logic [TW-1:0] TC = TW'(TICKS_PER_STEP - 1);

   logic [TW-1:0] tick;

   assign step_pulse = en && !clr && (tick == TC);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tick <= '0;
      end else if (clr) begin
         tick <= '0;
      end else if (en) begin
         tick <= (tick == TC) ? '0 : tick + 1'b1;
      end
   end

endmodule

// File: rtl/note_scroller.sv
// Playback stage: snapshots two lane patterns, scrolls them at a fixed tempo and judges presses.
// Optional streak counter and score bonus are built when SCROLL_STREAK_EN is defined.
//
// state     | meaning
// IDLE      | not playing; windows blank; snapshot taken when play mode is seen
// COUNTDOWN | lead-in steps before the first judged step; presses ignored
// PLAY      | presses judged against step_idx; steps close on step_pulse
// DONE      | step 0 closed; outputs held until play mode is left
module note_scroller
   import guitar_pkg::*;
#(
   parameter int TICKS_PER_STEP  = 1_000_000,
   parameter int COUNTDOWN_STEPS = 4,
   parameter int WINDOW          = 8,
   parameter int SCORE_W         = 8
`ifdef SCROLL_STREAK_EN
   , parameter int STREAK_THRESH = 4
`endif
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic [2:0]         mode,
   input  logic [31:0]        note1,
   input  logic [31:0]        note2,
   input  logic [1:0]         press,
   output logic [WINDOW-1:0]  lane1_win,
   output logic [WINDOW-1:0]  lane2_win,
   output logic [4:0]         step_idx,
   output logic [1:0]         state_o,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         hit_pulse,
   output logic [1:0]         miss_pulse,
   output logic               done
`ifdef SCROLL_STREAK_EN
   , output logic [4:0]       streak
`endif
);

   localparam logic [1:0] ST_IDLE      = IDLE;
   localparam logic [1:0] ST_COUNTDOWN = COUNTDOWN;
   localparam logic [1:0] ST_PLAY      = PLAY;
   localparam logic [1:0] ST_DONE      = DONE;

   localparam int CD_W = (COUNTDOWN_STEPS > 1) ? $clog2(COUNTDOWN_STEPS) : 1;

   logic [1:0]         state;
   logic [31:0]        sh1, sh2;
   logic [4:0]         step_q;
   logic [1:0]         hit_flag;
   logic [CD_W-1:0]    cd_left;
   logic               play_en, judge, step_pulse;
   logic [1:0]         open_note, hit_now, miss_now, n_hits;
   logic [2:0]         inc;
   logic [SCORE_W:0]   score_sum;
   logic [SCORE_W-1:0] score_next;

   assign play_en = (mode == MODE_PLAY);

   step_timer #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_step_timer (
      .clk        (clk),
      .nrst       (nrst),
      .clr        (!play_en || (state == ST_IDLE)),
      .en         ((state == ST_COUNTDOWN) || (state == ST_PLAY)),
      .step_pulse (step_pulse)
   );

   // A press coincident with step_pulse is judged first, so a hit there cancels the close miss.
   assign judge     = play_en && (state == ST_PLAY);
   assign open_note = {sh2[step_q], sh1[step_q]} & ~hit_flag;
   assign hit_now   = judge ? (press & open_note) : 2'b00;
   assign miss_now  = judge ? ((press & ~open_note) | ({2{step_pulse}} & open_note & ~press)) : 2'b00;
   assign n_hits    = {1'b0, hit_now[0]} + {1'b0, hit_now[1]};

`ifdef SCROLL_STREAK_EN
   logic [4:0] streak_q;
   logic [5:0] streak_sum;
   logic       bonus;

   assign bonus      = (32'(streak_q) >= STREAK_THRESH);
   assign inc        = bonus ? {n_hits, 1'b0} : {1'b0, n_hits};
   assign streak_sum = {1'b0, streak_q} + {4'b0, n_hits};
   assign streak     = streak_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         streak_q <= '0;
      end else if ((play_en && (state == ST_IDLE)) || (|miss_now)) begin
         streak_q <= '0;
      end else if (|hit_now) begin
         streak_q <= streak_sum[5] ? 5'd31 : streak_sum[4:0];
      end
   end
`else
   assign inc = {1'b0, n_hits};
`endif

   assign score_sum  = {1'b0, score} + (SCORE_W+1)'(inc);
   assign score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= ST_IDLE;
         sh1        <= '0;
         sh2        <= '0;
         step_q     <= 5'(SONG_LEN - 1);
         hit_flag   <= '0;
         cd_left    <= '0;
         score      <= '0;
         hit_pulse  <= '0;
         miss_pulse <= '0;
      end else begin
         hit_pulse  <= hit_now;
         miss_pulse <= miss_now;
         if (!play_en) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  sh1      <= note1;
                  sh2      <= note2;
                  score    <= '0;
                  hit_flag <= '0;
                  step_q   <= 5'(SONG_LEN - 1);
                  cd_left  <= CD_W'(COUNTDOWN_STEPS - 1);
                  state    <= ST_COUNTDOWN;
               end
               ST_COUNTDOWN: begin
                  if (step_pulse) begin
                     if (cd_left == '0) state <= ST_PLAY;
                     else               cd_left <= cd_left - 1'b1;
                  end
               end
               ST_PLAY: begin
                  score <= score_next;
                  if (step_pulse) begin
                     hit_flag <= '0;
                     if (step_q == 5'd0) state  <= ST_DONE;
                     else                step_q <= step_q - 1'b1;
                  end else begin
                     hit_flag <= hit_flag | hit_now;
                  end
               end
               ST_DONE: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   for (genvar k = 0; k < WINDOW; k++) begin : g_row
      assign lane1_win[k] = (state != ST_IDLE) && lane_row(sh1, step_q, k);
      assign lane2_win[k] = (state != ST_IDLE) && lane_row(sh2, step_q, k);
   end

   assign step_idx = step_q;
   assign state_o  = state;
   assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_note_scroller.sv
// Self-checking bench for note_scroller: elapsed-time song model, directed cases and random play.
module tb_note_scroller;

   localparam int T    = 4;
   localparam int CD   = 2;
   localparam int W    = 8;
   localparam int SW   = 5;
   localparam int SMAX = (1 << SW) - 1;

   logic          clk, nrst;
   logic [2:0]    mode;
   logic [31:0]   note1, note2;
   logic [1:0]    press;
   logic [W-1:0]  lane1_win, lane2_win;
   logic [4:0]    step_idx;
   logic [1:0]    state_o;
   logic [SW-1:0] score;
   logic [1:0]    hit_pulse, miss_pulse;
   logic          done;

   note_scroller #(.TICKS_PER_STEP(T), .COUNTDOWN_STEPS(CD), .WINDOW(W), .SCORE_W(SW)) dut (
      .clk(clk), .nrst(nrst), .mode(mode), .note1(note1), .note2(note2), .press(press),
      .lane1_win(lane1_win), .lane2_win(lane2_win), .step_idx(step_idx), .state_o(state_o),
      .score(score), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .done(done)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0, miss0 = 0;

   // Song model: m_e counts cycles since the snapshot; the phase and closing cycles follow from it.
   bit          m_busy, m_done;
   int          m_e, m_step, m_score;
   logic [31:0] m_sh1, m_sh2;
   bit   [1:0]  m_hf, m_hp, m_mp;

   function automatic void m_reset();
      m_busy = 0; m_done = 0; m_e = 0; m_step = 31; m_score = 0;
      m_sh1 = '0; m_sh2 = '0; m_hf = '0; m_hp = '0; m_mp = '0;
   endfunction

   function automatic void m_clock();
      bit [1:0] nb;
      int s, hits;
      m_hp = '0; m_mp = '0;
      if (mode != 3'd3) begin m_busy = 0; m_done = 0; return; end
      if (!m_busy) begin
         m_busy = 1; m_done = 0; m_e = 0; m_step = 31; m_score = 0; m_hf = '0;
         m_sh1 = note1; m_sh2 = note2;
         return;
      end
      if (m_done) return;
      if (m_e >= T*CD) begin
         s    = 31 - (m_e - T*CD) / T;
         nb   = {m_sh2[s], m_sh1[s]};
         hits = 0;
         for (int l = 0; l < 2; l++)
            if (press[l]) begin
               if (nb[l] && !m_hf[l]) begin m_hp[l] = 1; m_hf[l] = 1; hits++; end
               else m_mp[l] = 1;
            end
         if ((m_e % T) == T-1) begin
            for (int l = 0; l < 2; l++) if (nb[l] && !m_hf[l]) m_mp[l] = 1;
            m_hf = '0;
            if (s == 0) m_done = 1; else m_step = s - 1;
         end
         m_score = (m_score + hits > SMAX) ? SMAX : m_score + hits;
      end
      m_e++;
   endfunction

   function automatic int exp_state();
      if (!m_busy) return 0;
      if (m_done)  return 3;
      return (m_e < T*CD) ? 1 : 2;
   endfunction

   function automatic logic [W-1:0] m_win(input logic [31:0] sh);
      logic [W-1:0] w;
      w = '0;
      for (int k = 0; k < W; k++) if (m_busy && k <= m_step) w[k] = sh[m_step-k];
      return w;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic compare_all();
      chk("state_o",    32'(state_o),    32'(exp_state()));
      chk("step_idx",   32'(step_idx),   32'(m_step));
      chk("score",      32'(score),      32'(m_score));
      chk("hit_pulse",  32'(hit_pulse),  32'(m_hp));
      chk("miss_pulse", 32'(miss_pulse), 32'(m_mp));
      chk("done",       32'(done),       32'(m_busy && m_done));
      chk("lane1_win",  32'(lane1_win),  32'(m_win(m_sh1)));
      chk("lane2_win",  32'(lane2_win),  32'(m_win(m_sh2)));
   endtask

   task automatic cyc();
      @(posedge clk);
      if (nrst) m_clock(); else m_reset();
      @(negedge clk);
      press = '0;
      compare_all();
      if (miss_pulse[0]) miss0++;
   endtask

   task automatic run_to_play();
      int b = 0;
      while (exp_state() != 2 && b < 100) begin cyc(); b++; end
      chk("reach_play", 32'(state_o), 32'd2);
   endtask

   task automatic run_to_done();
      int b = 0;
      while (!(m_busy && m_done) && b < 300) begin cyc(); b++; end
      chk("reach_done", 32'(done), 32'd1);
   endtask

   task automatic wait_close();
      int b = 0;
      while (!(m_busy && !m_done && m_e >= T*CD && (m_e % T) == T-1) && b < 20) begin cyc(); b++; end
   endtask

   task automatic restart(input logic [31:0] n1, input logic [31:0] n2);
      mode = 3'd2; cyc();
      note1 = n1; note2 = n2; mode = 3'd3; cyc();
   endtask

   initial begin
      nrst = 0; mode = 3'd0; note1 = '0; note2 = '0; press = '0;
      m_reset();
      #12;
      compare_all();
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_step",  32'(step_idx), 32'd31);
      @(negedge clk) nrst = 1;
      cyc();

      // single lane-1 note hit on the 2nd cycle of step 31
      restart(32'h8000_0000, 32'h0);
      run_to_play();
      cyc();
      press = 2'b01; cyc();
      chk("t2_hit",   32'(hit_pulse), 32'd1);
      chk("t2_score", 32'(score), 32'd1);
      cyc(); cyc();
      chk("t2_no_close_miss", 32'(miss_pulse), 32'd0);
      chk("t2_step",  32'(step_idx), 32'd30);
      run_to_done();

      // unplayed notes on steps 31 and 30
      restart(32'hC000_0000, 32'h0);
      miss0 = 0;
      run_to_done();
      chk("t3_miss_cnt", 32'(miss0), 32'd2);
      chk("t3_score",    32'(score), 32'd0);

      // empty lane press, then double press on a hit step
      restart(32'h8000_0000, 32'h0);
      run_to_play();
      press = 2'b10; cyc();
      chk("t4_empty_miss", 32'(miss_pulse), 32'd2);
      chk("t4_score0",     32'(score), 32'd0);
      press = 2'b01; cyc();
      chk("t4_hit", 32'(hit_pulse), 32'd1);
      press = 2'b01; cyc();
      chk("t4_repress_miss", 32'(miss_pulse), 32'd1);
      chk("t4_score1",       32'(score), 32'd1);

      // press on the closing cycle of a lane-2 note
      restart(32'h0, 32'h8000_0000);
      run_to_play();
      wait_close();
      press = 2'b10; cyc();
      chk("t5_hit",   32'(hit_pulse), 32'd2);
      chk("t5_miss",  32'(miss_pulse), 32'd0);
      chk("t5_step",  32'(step_idx), 32'd30);
      chk("t5_score", 32'(score), 32'd1);

      // leave play mid-song and re-enter with a new pattern
      mode = 3'd2; cyc();
      chk("t6_idle", 32'(state_o), 32'd0);
      note1 = 32'hC100_0000; mode = 3'd3; cyc();
      chk("t6_cd",    32'(state_o), 32'd1);
      chk("t6_score", 32'(score), 32'd0);
      chk("t6_win",   32'(lane1_win), 32'h83);

      // every step hit on both lanes drives the score into saturation
      restart('1, '1);
      while (!m_done && m_e < 400) begin
         if (m_e >= T*CD && (m_e % T) == 1) press = 2'b11;
         cyc();
      end
      chk("sat_score", 32'(score), 32'(SMAX));

      for (int r = 0; r < 6; r++) begin
         restart($urandom, $urandom);
         for (int i = 0; i < 180; i++) begin
            if ($urandom_range(0, 2) == 0) press = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 29) == 0) note1 = $urandom;
            mode = ($urandom_range(0, 149) == 0) ? 3'd2 : 3'd3;
            cyc();
         end
      end

      // asynchronous reset in the middle of play
      restart('1, 32'h0);
      run_to_play();
      press = 2'b01; cyc();
      nrst = 0;
      #1;
      m_reset();
      compare_all();
      chk("rst_mid_state", 32'(state_o), 32'd0);
      chk("rst_mid_hit",   32'(hit_pulse), 32'd0);
      chk("rst_mid_win",   32'(lane1_win), 32'd0);
      cyc(); cyc();
      nrst = 1;
      for (int i = 0; i < 12; i++) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
